// File: rtl/freq_meas_scheduler.sv
// Round-robin equal-precision frequency meter: one shared period-counting datapath
// serves two asynchronous square-wave channels, results leave on valid/ready.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | waiting for enable with a non-empty channel mask
// S_SELECT| pick next channel round-robin, preload timer, clear counters
// S_ARM   | waiting for the start edge of the selected channel
// S_COUNT | counting pll_clk ticks across N_CYCLES input periods
// S_DONE  | result held on res_* until the consumer accepts it
module freq_meas_scheduler #(
    parameter int N_CYCLES    = 16,
    parameter int TIMEOUT_CYC = 20_000_000,
    parameter int CNT_W       = 32
) (
    input  logic             pll_clk,
    input  logic             sys_rst_n,
    input  logic             enable,
    input  logic [1:0]       ch_mask,
    input  logic [1:0]       wave_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_ch,
    output logic [CNT_W-1:0] res_ticks,
    output logic [15:0]      res_periods,
    output logic             res_timeout,
    output logic             busy
);

    if (N_CYCLES < 2 || N_CYCLES > 65535) begin : g_bad_n_cycles
        $error("freq_meas_scheduler: N_CYCLES must be in 2..65535");
    end
    if (TIMEOUT_CYC < 1 || (CNT_W < 32 && longint'(TIMEOUT_CYC) >= (longint'(1) << CNT_W)))
    begin : g_bad_timeout
        $error("freq_meas_scheduler: TIMEOUT_CYC must be >= 1 and < 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] LP_TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [15:0]      LP_N       = 16'(N_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ARM,
        S_COUNT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_dly;
    logic             r_cur_ch;
    logic             r_last_ch;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] r_tick;
    logic [15:0]      r_periods;
    logic             r_res_valid;
    logic             r_res_ch;
    logic [CNT_W-1:0] r_res_ticks;
    logic [15:0]      r_res_periods;
    logic             r_res_timeout;
    logic             r_busy;

    logic [1:0] w_rise;
    logic       w_rise_cur;
    logic       w_go;
    logic       w_nxt_ch;
    logic       w_to_hit;
    logic       w_final;

    assign w_rise     = r_sync2 & ~r_dly;
    assign w_rise_cur = w_rise[r_cur_ch];
    assign w_go       = enable & (|ch_mask);
    assign w_nxt_ch   = ch_mask[~r_last_ch] ? ~r_last_ch : r_last_ch;
    // Timer counts down from TIMEOUT_CYC-1; terminal count at zero is the timeout cycle.
    assign w_to_hit   = (r_timer == '0);
    assign w_final    = w_rise_cur && (r_periods == LP_N - 16'd1);

    always_ff @(posedge pll_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state       <= S_IDLE;
            r_sync1       <= '0;
            r_sync2       <= '0;
            r_dly         <= '0;
            r_cur_ch      <= 1'b0;
            r_last_ch     <= 1'b1;
            r_timer       <= '0;
            r_tick        <= '0;
            r_periods     <= '0;
            r_res_valid   <= 1'b0;
            r_res_ch      <= 1'b0;
            r_res_ticks   <= '0;
            r_res_periods <= '0;
            r_res_timeout <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_sync1 <= wave_in;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;

            case (r_state)
                S_IDLE: begin
                    if (w_go) r_state <= S_SELECT;
                end
                S_SELECT: begin
                    if (!w_go) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cur_ch  <= w_nxt_ch;
                        r_last_ch <= w_nxt_ch;
                        r_timer   <= LP_TO_LAST;
                        r_tick    <= '0;
                        r_periods <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_ARM;
                    end
                end
                S_ARM, S_COUNT: begin
                    if (!enable) begin
                        r_timer   <= '0;
                        r_tick    <= '0;
                        r_periods <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (r_state == S_COUNT && w_final) begin
                        // tick was zeroed the cycle after the start edge, hence +1
                        r_res_ticks   <= r_tick + CNT_W'(1);
                        r_res_periods <= LP_N;
                        r_res_timeout <= 1'b0;
                        r_res_ch      <= r_cur_ch;
                        r_res_valid   <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_DONE;
                    end else if (w_to_hit) begin
                        r_res_ticks   <= '0;
                        r_res_periods <= r_periods;
                        r_res_timeout <= 1'b1;
                        r_res_ch      <= r_cur_ch;
                        r_res_valid   <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_DONE;
                    end else begin
                        r_timer <= r_timer - CNT_W'(1);
                        if (r_state == S_ARM) begin
                            if (w_rise_cur) begin
                                r_tick    <= '0;
                                r_periods <= '0;
                                r_state   <= S_COUNT;
                            end
                        end else begin
                            r_tick <= r_tick + CNT_W'(1);
                            if (w_rise_cur) r_periods <= r_periods + 16'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (r_res_valid && res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= w_go ? S_SELECT : S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign res_valid   = r_res_valid;
    assign res_ch      = r_res_ch;
    assign res_ticks   = r_res_ticks;
    assign res_periods = r_res_periods;
    assign res_timeout = r_res_timeout;
    assign busy        = r_busy;

endmodule

// File: doc/freq_meas_scheduler.md
Name: freq_meas_scheduler

Overview:
Measurement controller that shares one equal-precision period-counting datapath between the two square-wave inputs. It runs entirely in the 200 MHz pll_clk domain and sequences each measurement: channel select, arm, N-period count and timeout. Results go out on a valid/ready interface to the readout logic. Enabled channels are served round-robin.

Parameters:
N_CYCLES, 16, input periods counted per measurement (2..65535)
TIMEOUT_CYC, 20_000_000, pll_clk cycles allowed per measurement (100 ms at 200 MHz); must be < 2^CNT_W
CNT_W, 32, width of the tick counter and res_ticks

Ports:
pll_clk      in   1      measurement clock, 200 MHz, the only clock
sys_rst_n    in   1      asynchronous active-low reset
enable       in   1      high = schedule measurements
ch_mask      in   2      bit i = channel i eligible; sampled when a channel is selected
wave_in      in   2      asynchronous square-wave inputs
res_valid    out  1      result available
res_ready    in   1      consumer accepts result
res_ch       out  1      channel of the result
res_ticks    out  CNT_W  pll_clk cycles spanning N_CYCLES periods; 0 on timeout
res_periods  out  16     periods completed (N_CYCLES normally; fewer on timeout)
res_timeout  out  1      measurement ended by timeout
busy         out  1      high in ARM or COUNT

Behaviour:
- Reset (async, sys_rst_n low):
  - state=IDLE, cur_ch=0, all counters 0.
  - All outputs 0.
  - Synchronizer flops 0.
- Input conditioning, per channel:
  - 2-flop synchronizer, then a 3rd flop for edge detect.
  - rise_i = sync_i & ~dly_i.
  - Fixed latency of 3 cycles, identical at start and end, so it cancels out of res_ticks.
- IDLE:
  - If enable=1 and ch_mask!=0, go to SELECT; otherwise stay.
- SELECT (1 cycle):
  - cur_ch = the next enabled channel after the last-served one; if only one is enabled, that one. The first pick after reset is ch0 when enabled.
  - Clear the timer, tick counter and period counter.
  - Go to ARM.
- ARM:
  - Timer increments every cycle.
  - On rise_cur, go to COUNT with tick=0, periods=0.
- COUNT:
  - Tick and timer increment every cycle.
  - On rise_cur, periods++.
  - When periods reaches N_CYCLES on a rise, latch res_ticks = cycles between the start-edge detect and this edge detect, res_periods=N_CYCLES, res_timeout=0, res_ch=cur_ch. Then go to DONE.
- Timeout (ARM or COUNT):
  - When timer reaches TIMEOUT_CYC-1, latch res_ticks=0, res_periods=current periods, res_timeout=1, res_ch=cur_ch. Go to DONE.
  - If final edge and timeout fall in the same cycle, the final edge wins.
- DONE:
  - res_valid=1 from the cycle after entry.
  - Result fields stay stable while res_valid=1 and res_ready=0.
  - Transfer happens on res_valid&res_ready; res_valid drops the next cycle.
  - After transfer: go to SELECT if enable=1 and ch_mask!=0, else IDLE.
- enable=0 during ARM or COUNT: go to IDLE next cycle, no result produced, counters cleared.
- enable=0 during DONE: the pending result still completes its handshake, then IDLE.
- ch_mask change: takes effect only at the next SELECT. A channel in progress is never interrupted by a mask change.
- Outputs:
  - busy is registered and equals (state==ARM | state==COUNT).
  - res_* are registered outputs.
- Width: the tick counter cannot overflow because TIMEOUT_CYC < 2^CNT_W. An elaboration check rejects a violating TIMEOUT_CYC.
- Reset mid-measurement: immediate return to reset values; no partial result is ever emitted.

Test Plan:
1. mask=01, ch0 period 40 cycles (5 MHz), res_ready=1, N=16 -> res_valid pulse with ch=0, ticks=640, periods=16, timeout=0. Repeats every measurement.
2. mask=11, ch0 period 40, ch1 period 100 -> results alternate ch0/ch1 with ticks=640 and 1600. First result is ch0.
3. TIMEOUT_CYC=1000, mask=11, ch1 held low -> ch1 result timeout=1, ticks=0, periods=0, exactly 1000 cycles after ARM entry. Then ch0 is measured normally.
4. ch0 stops after 5 periods, TIMEOUT_CYC=1000 -> timeout=1, periods=5, ticks=0.
5. res_ready held low 50 cycles in DONE -> res_valid stays 1, fields unchanged, busy=0, no new measurement until the handshake.
6. enable dropped mid-COUNT, and separately sys_rst_n pulsed mid-COUNT -> no res_valid; state IDLE; all outputs 0 after reset. mask=00 with enable=1 -> busy and res_valid never assert.
